// File: rtl/dbg_trace.sv
// dbg_trace: PC-breakpoint triggered instruction trace buffer with APB access.
// Packages are captured into a circular RAM while armed; a breakpoint hit
// optionally runs a post-trigger count before the capture freezes in STOPPED.
module dbg_trace #(
   parameter int PKG_W  = 256,
   parameter int DEPTH  = 128,
   parameter int NUM_BP = 4,
   parameter int PC_LSB = 160
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [12:0]      paddr,
   input  logic [31:0]      pwdata,
   output logic [31:0]      prdata,
   output logic             pready,
   output logic             pslverr,
   input  logic             pkg_valid,
   input  logic [PKG_W-1:0] pkg,
   output logic             trig_out
);
   localparam int AW     = $clog2(DEPTH);
   localparam int BW     = $clog2(PKG_W/8);
   localparam int WW     = BW - 2;
   localparam int NWORDS = PKG_W/32;

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, STOPPED = 2'd3} state_t;

   state_t            state_reg;
   logic [AW-1:0]     wr_ptr_reg;
   logic [12:0]       count_reg;
   logic              wrapped_reg;
   logic [11:0]       post_cnt_reg;
   logic [11:0]       post_ctr_reg;
   logic [NUM_BP-1:0] bp_en_reg;
   logic [63:0]       bp_reg [NUM_BP];
   logic              trig_reg;
   logic [31:0]       reg_rdata_reg;
   logic              sel_ram_reg;
   logic [WW-1:0]     word_reg;
   logic              err_reg;
   logic [PKG_W-1:0]  ram [DEPTH];
   logic [PKG_W-1:0]  ram_rd_reg;

   // APB decode
   logic          setup, is_reg, word_ok, reg_ok, acc_err, wr_en, ctrl_wr;
   logic          sel_ctrl, sel_status, sel_post, sel_bpen, sel_bp;
   logic [12:0]   k_ext;
   logic [WW-1:0] w_idx;
   logic [4:0]    bp_idx;
   logic [AW-1:0] phys;
   logic          rd_en;
   logic [31:0]   bp_rd, reg_rd, ram_word;

   assign setup      = psel & ~penable;
   assign is_reg     = paddr[12];
   assign k_ext      = 13'(paddr[11:BW]);
   assign w_idx      = paddr[BW-1:2];
   assign bp_idx     = paddr[7:3];
   assign sel_ctrl   = (paddr == 13'h1000);
   assign sel_status = (paddr == 13'h1004);
   assign sel_post   = (paddr == 13'h1008);
   assign sel_bpen   = (paddr == 13'h100C);
   assign sel_bp     = (paddr[12:8] == 5'h11) && (paddr[1:0] == 2'b00) && (32'(bp_idx) < NUM_BP);
   assign word_ok    = (32'(w_idx) < NWORDS);
   assign reg_ok     = sel_ctrl | sel_status | sel_post | sel_bpen | sel_bp;
   assign acc_err    = is_reg ? ~reg_ok : (pwrite | (k_ext >= 13'(DEPTH)) | ~word_ok);
   assign wr_en      = setup & pwrite & ~acc_err;
   assign ctrl_wr    = wr_en & sel_ctrl;

   // Offset 0 is the oldest entry: once wrapped it sits at the write pointer
   assign phys  = wrapped_reg ? (wr_ptr_reg + k_ext[AW-1:0]) : k_ext[AW-1:0];
   assign rd_en = setup & ~pwrite & ~is_reg & ~acc_err & (state_reg == STOPPED) & (k_ext < count_reg);

   // Breakpoint comparators
   logic [NUM_BP-1:0] bp_match;
   logic              hit, capture;
   generate
      for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
         assign bp_match[gi] = bp_en_reg[gi] && (pkg[PC_LSB +: 64] == bp_reg[gi]);
      end
   endgenerate
   assign hit     = pkg_valid & (|bp_match);
   assign capture = pkg_valid & ((state_reg == ARMED) | (state_reg == POST)) & ~ctrl_wr;

   // Breakpoint register read mux
   always_comb begin
      bp_rd = 32'd0;
      for (int n = 0; n < NUM_BP; n++)
         if (32'(bp_idx) == n) bp_rd = paddr[2] ? bp_reg[n][63:32] : bp_reg[n][31:0];
   end

   // Control register read mux (CTRL reads back as zero)
   always_comb begin
      reg_rd = 32'd0;
      if (sel_status)    reg_rd = {3'b000, count_reg, 13'd0, wrapped_reg, state_reg};
      else if (sel_post) reg_rd = {20'd0, post_cnt_reg};
      else if (sel_bpen) reg_rd = 32'(bp_en_reg);
      else if (sel_bp)   reg_rd = bp_rd;
   end

   // Select the addressed 32-bit word of the registered trace entry
   always_comb begin
      ram_word = 32'd0;
      for (int i = 0; i < NWORDS; i++)
         if (32'(word_reg) == i) ram_word = ram_rd_reg[i*32 +: 32];
   end

   assign prdata   = sel_ram_reg ? ram_word : reg_rdata_reg;
   assign pslverr  = err_reg;
   assign pready   = 1'b1;
   assign trig_out = trig_reg;

   // Trace FSM, capture bookkeeping, configuration registers and APB response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         wrapped_reg   <= 1'b0;
         post_cnt_reg  <= '0;
         post_ctr_reg  <= '0;
         bp_en_reg     <= '0;
         for (int n = 0; n < NUM_BP; n++) bp_reg[n] <= '0;
         trig_reg      <= 1'b0;
         reg_rdata_reg <= '0;
         sel_ram_reg   <= 1'b0;
         word_reg      <= '0;
         err_reg       <= 1'b0;
      end else begin
         trig_reg <= 1'b0;
         if (ctrl_wr) begin
            // A CTRL write wins over any capture in the same cycle
            if (pwdata[0] | pwdata[1]) begin
               state_reg   <= pwdata[0] ? ARMED : IDLE;
               wr_ptr_reg  <= '0;
               count_reg   <= '0;
               wrapped_reg <= 1'b0;
            end
         end else if (capture) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (count_reg != 13'(DEPTH)) count_reg <= count_reg + 13'd1;
            if (wr_ptr_reg == AW'(DEPTH-1)) wrapped_reg <= 1'b1;
            if (state_reg == ARMED) begin
               if (hit) begin
                  if (post_cnt_reg == 12'd0) begin
                     state_reg <= STOPPED;
                     trig_reg  <= 1'b1;
                  end else begin
                     post_ctr_reg <= post_cnt_reg;
                     state_reg    <= POST;
                  end
               end
            end else begin
               post_ctr_reg <= post_ctr_reg - 12'd1;
               if (post_ctr_reg == 12'd1) begin
                  state_reg <= STOPPED;
                  trig_reg  <= 1'b1;
               end
            end
         end
         if (wr_en & sel_post) post_cnt_reg <= pwdata[11:0];
         if (wr_en & sel_bpen) bp_en_reg <= pwdata[NUM_BP-1:0];
         for (int n = 0; n < NUM_BP; n++) begin
            if (wr_en & sel_bp & (32'(bp_idx) == n)) begin
               if (paddr[2]) bp_reg[n][63:32] <= pwdata;
               else          bp_reg[n][31:0]  <= pwdata;
            end
         end
         if (setup) begin
            err_reg       <= acc_err;
            sel_ram_reg   <= rd_en;
            word_reg      <= w_idx;
            reg_rdata_reg <= (~pwrite & is_reg & ~acc_err) ? reg_rd : 32'd0;
         end else begin
            err_reg <= 1'b0;
         end
      end
   end

   // Trace RAM: one write port for capture, one registered read port for APB
   always_ff @(posedge clk) begin
      if (capture & ~rst) ram[wr_ptr_reg] <= pkg;
      if (rd_en) ram_rd_reg <= ram[phys];
   end
endmodule

// File: doc/dbg_trace.md
DBG_TRACE -- requirements
Module: dbg_trace

Interface
REQ-001 SHALL have parameter PKG_W, default 256, meaning the trace package width in bits, which SHALL be a multiple of 32 and at least 128.
REQ-002 SHALL have parameter DEPTH, default 128, meaning the number of trace entries, which SHALL be a power of 2 between 16 and 4096/(PKG_W/8).
REQ-003 SHALL have parameter NUM_BP, default 4, meaning the number of PC breakpoints (1..8).
REQ-004 SHALL have parameter PC_LSB, default 160, meaning the bit offset of the 64-bit PC field inside pkg.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have APB slave ports psel, penable, pwrite (input, 1 bit each); paddr (input, 13 bits); pwdata (input, 32 bits).
REQ-008 SHALL have APB slave ports prdata (output, 32 bits), pready (output, 1 bit), pslverr (output, 1 bit).
REQ-009 SHALL have port pkg_valid, input, 1 bit: pkg is a retired-instruction package this cycle.
REQ-010 SHALL have port pkg, input, PKG_W bits: the trace package.
REQ-011 SHALL have port trig_out, output, 1 bit: a one-cycle pulse on entry to STOPPED.

Function
REQ-012 SHALL use the following register map (paddr[12]=1): CTRL 0x1000 (bit0 ARM, bit1 CLR, write-only, self-clearing); STATUS 0x1004 RO ({state[1:0] at [1:0], wrapped at [2], count at [28:16]}); POST_CNT 0x1008 RW, 12 bits; BP_EN 0x100C RW, NUM_BP bits; BPn lo/hi at 0x1100+8n / 0x1104+8n RW.
REQ-013 SHALL implement states IDLE=0, ARMED=1, POST=2, STOPPED=3.
REQ-014 SHALL transition as follows: ARM write -> ARMED from any state, with wr_ptr=0, count=0, wrapped=0; CLR write -> IDLE, with wr_ptr=0, count=0, wrapped=0.
REQ-015 SHALL define hit as pkg_valid AND, for some n, BP_EN[n]=1 and pkg[PC_LSB+:64]==BPn.
REQ-016 SHALL capture in ARMED and POST: pkg_valid writes pkg at wr_ptr; wr_ptr increments modulo DEPTH; count saturates at DEPTH; wrapped is set when wr_ptr wraps from DEPTH-1 to 0.
REQ-017 SHALL always capture the hitting package before acting on the hit.
REQ-018 SHALL, on a hit in ARMED, go to STOPPED if POST_CNT==0, else load post counter=POST_CNT and go to POST.
REQ-019 SHALL, in POST, decrement the post counter on each captured package, and the capture that takes it to 0 SHALL move the block to STOPPED; further hits in POST SHALL be ignored.
REQ-020 SHALL perform no capture in IDLE or STOPPED.
REQ-021 SHALL, when an APB CTRL write and a hit/capture occur in the same cycle, apply the CTRL write and discard the capture.
REQ-022 SHALL take APB register writes in the setup phase (psel & ~penable & pwrite).
REQ-023 SHALL register read data in the setup phase and present it on prdata in the access phase; pready SHALL be constantly 1.
REQ-024 SHALL decode trace reads (paddr[12]=0) as: entry offset k = paddr[11:log2(PKG_W/8)], word w = paddr[log2(PKG_W/8)-1:2].
REQ-025 SHALL read physical entry (wrapped ? wr_ptr+k : k) mod DEPTH, so that offset 0 is always the oldest entry.
REQ-026 SHALL return 0 for a trace read when state!=STOPPED or k>=count.
REQ-027 SHALL assert pslverr in the access phase for unmapped register addresses, trace offsets k>=DEPTH, and writes to the trace region; such accesses SHALL have no side effects.

Reset
REQ-028 SHALL, under rst=1, set state=IDLE, wr_ptr=0, count=0, wrapped=0, POST_CNT=0, BP_EN=0, all BPn=0, prdata=0, pslverr=0, trig_out=0.
REQ-029 SHALL abort capture when rst is asserted mid-operation, and trace RAM contents SHALL not be cleared.

Verification
REQ-030 SHALL test: BP0=0x80000010, BP_EN=1, POST_CNT=0, ARM, 5 packages with the last PC=0x80000010 -> STOPPED, count=5, trig_out pulses once, entry 4 PC readback is 0x80000010.
REQ-031 SHALL test: POST_CNT=3, hit on package 2 -> STOPPED after package 5, count=5, further pkg_valid does not change count.
REQ-032 SHALL test: DEPTH+10 packages with PC=i, then hit -> wrapped=1, count=DEPTH, offset 0 reads PC=11 (oldest retained).
REQ-033 SHALL test: ARM write coincident with a hitting pkg_valid -> ARMED, count=0.
REQ-034 SHALL test: trace read at offset 3 while ARMED -> prdata=0, pslverr=0; a read at 0x1010 -> pslverr=1.
REQ-035 SHALL test: rst asserted during POST -> IDLE, STATUS=0, all BP registers read 0.
